whistle_sequence_decoder: RTL and testbench
===========================================

# whistle_sequence_decoder

Converts the single-cycle whistle and beep detection pulses from the FFT pitch detector into discrete user commands. Retriggerable hold-off merges one sustained whistle into a single event. Consecutive whistles are counted until an inter-whistle gap times out. The count is presented as a command code on a valid/ready interface to the robot/controller logic. A beep cancels a sequence in progress. The block sits downstream of `fft_pitch_detect`, in the `CLOCK_50` domain, in place of the LED pulse stretchers.

## Interface
- `HOLDOFF_CYCLES`, default 12_500_000: cycles of whistle silence that close one whistle event (0.25 s at 50 MHz); must be ≥2.
- `GAP_CYCLES`, default 50_000_000: cycles of silence after an event that close the sequence (1 s); must be ≥2.
- `MAX_COUNT`, default 7: saturation value of the whistle count; must be ≥1.
- `CW`, default 3: command code width; must satisfy `MAX_COUNT` < 2^CW.
- `clk`  in  1  system clock (`CLOCK_50`).
- `reset_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `whistle_pulse`  in  1  single-cycle whistle detection, already synchronous to `clk`.
- `beep_pulse`  in  1  single-cycle beep detection, already synchronous to `clk`.
- `cmd_ready`  in  1  consumer accepts the command when high together with `cmd_valid`.
- `cmd_valid`  out  1  command available.
- `cmd_code`  out  CW  number of whistles in the sequence, 1..`MAX_COUNT`.
- `abort_pulse`  out  1  one-cycle pulse: sequence cancelled by beep.
- `drop_pulse`  out  1  one-cycle pulse: whistle ignored while a command was pending.
- `busy`  out  1  high in any state other than IDLE.
- `live_count`  out  CW  running count, intended for HEX display.

## Operation
- States: IDLE, HOLDOFF, GAP, PRESENT.
- One timer counts up from 0. Width is `$clog2(max(HOLDOFF_CYCLES, GAP_CYCLES))`. It is cleared on every state entry.
- IDLE:
  - `whistle_pulse` → count=1, go to HOLDOFF.
  - `beep_pulse` is ignored.
- HOLDOFF:
  - `whistle_pulse` → timer=0 (retrigger); the count does not change.
  - Timer = `HOLDOFF_CYCLES`-1 with no whistle in that cycle → go to GAP.
- GAP:
  - `whistle_pulse` → count = min(count+1, `MAX_COUNT`), go to HOLDOFF.
  - Timer = `GAP_CYCLES`-1 with no whistle → go to PRESENT, `cmd_code` = count.
- PRESENT:
  - `cmd_valid`=1 and `cmd_code` are held stable until `cmd_ready`=1.
  - On accept → count=0, go to IDLE.
  - `whistle_pulse` → `drop_pulse` for one cycle; state is unchanged.
  - `beep_pulse` is ignored.
- Beep in HOLDOFF or GAP → count=0, `abort_pulse`=1 for one cycle, go to IDLE.
- Simultaneous whistle and beep in HOLDOFF or GAP → the beep wins; the abort path is taken.
- `live_count` equals the internal count; it is 0 in IDLE.

## Timing
- All outputs are registered.
- Reset values: `cmd_valid`=0, `cmd_code`=0, `abort_pulse`=0, `drop_pulse`=0, `busy`=0, `live_count`=0, state=IDLE, timer=0.
- Reset mid-operation discards any pending command with no pulse output. The next cycle is IDLE.
- Whistle sampled at edge t in IDLE → `busy`=1 and `live_count`=1 visible after edge t.
- Let t be the last whistle edge. `cmd_valid` rises after edge t + `HOLDOFF_CYCLES` + `GAP_CYCLES` + 1.
  - t + `HOLDOFF_CYCLES`: HOLDOFF exit.
  - + `GAP_CYCLES`: GAP expiry.
  - +1: PRESENT registered.
- Accept at edge a → `cmd_valid`=0 and `busy`=0 after edge a. A whistle at edge a+1 starts a new sequence.
- If `cmd_ready` is already high when `cmd_valid` rises, the handshake completes in one cycle.
- The count saturates at `MAX_COUNT`; it never wraps.

## Structure
- Package `whistle_cmd_pkg`: state enum `wsd_state_t` {IDLE, HOLDOFF, GAP, PRESENT} and default `CW` constant. The package is shared with the command consumer.
- Sub-module `event_timer`:
  - Parameter `MAX`.
  - Ports: `clk`, `reset_n`, `clear`, `en`, `done`.
  - `done` is high when count = `MAX`-1.
  - The top instantiates one timer and drives `MAX` per state via two instances, or one timer with a runtime limit input (implementer's choice). Behaviour must match the above.

## Test plan
All scenarios use `HOLDOFF_CYCLES`=4, `GAP_CYCLES`=8, `MAX_COUNT`=7, `CW`=3.

1. One whistle pulse at cycle 10, `cmd_ready`=1 → `cmd_valid` high for exactly one cycle after edge 23, `cmd_code`=1. Then `busy`=0.
2. Whistle pulses at 10, 12, 14, 16 (retriggering HOLDOFF) → one event; `cmd_code`=1. `cmd_valid` rises after edge 29.
3. Three whistles separated by 6-cycle gaps (exit HOLDOFF, re-enter from GAP) → `cmd_code`=3. `live_count` steps 1→2→3.
4. Ten separated whistles → `cmd_code`=7 (saturated).
5. Two whistles, then beep during GAP → `abort_pulse` for one cycle, `busy`=0, no `cmd_valid`.
6. Whistle and beep on the same edge in HOLDOFF → abort. Separately: `cmd_ready`=0 for 20 cycles in PRESENT with one whistle injected → `drop_pulse` for one cycle, `cmd_code` unchanged. `reset_n`=0 in PRESENT → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/whistle_cmd_pkg.sv
// Shared definitions for the whistle sequence decoder and its command consumer.
package whistle_cmd_pkg;

    // Decoder sequencing states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLDOFF = 2'd1,
        GAP     = 2'd2,
        PRESENT = 2'd3
    } wsd_state_t;

    // Default command code width; holds counts up to 7.
    localparam int WSD_CW_DEFAULT = 3;

endpackage : whistle_cmd_pkg

// File: rtl/event_timer.sv
// Up-counting interval timer. done flags the last cycle of a MAX-cycle window.
module event_timer #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic done
);

    localparam int CNT_W = (MAX > 1) ? $clog2(MAX) : 1;

    logic [CNT_W-1:0] count;

    // Count up while enabled; clear has priority so every window starts at 0.
    always_ff @(posedge clk) begin
        // NOTE: registers take <= so every flop samples pre-edge values.
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done = (count == CNT_W'(MAX - 1));

endmodule : event_timer

// File: rtl/whistle_sequence_decoder.sv
// Turns whistle/beep detection pulses into a counted command on a valid/ready port.
module whistle_sequence_decoder
    import whistle_cmd_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = 12_500_000,
    parameter int GAP_CYCLES     = 50_000_000,
    parameter int MAX_COUNT      = 7,
    parameter int CW             = WSD_CW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          whistle_pulse,
    input  logic          beep_pulse,
    input  logic          cmd_ready,
    output logic          cmd_valid,
    output logic [CW-1:0] cmd_code,
    output logic          abort_pulse,
    output logic          drop_pulse,
    output logic          busy,
    output logic [CW-1:0] live_count
);

    wsd_state_t    state;
    logic [CW-1:0] count;
    logic          hold_done;
    logic          gap_done;
    logic          hold_clear;
    logic          gap_clear;

    // Hold-off window restarts on every whistle so a sustained whistle stays one event.
    assign hold_clear = (state != HOLDOFF) || whistle_pulse;
    assign gap_clear  = (state != GAP);

    event_timer #(
        .MAX (HOLDOFF_CYCLES)
    ) u_hold_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (hold_clear),
        .en      (state == HOLDOFF),
        .done    (hold_done)
    );

    event_timer #(
        .MAX (GAP_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (gap_clear),
        .en      (state == GAP),
        .done    (gap_done)
    );

    // Sequencer with registered outputs; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= '0;
            cmd_valid   <= 1'b0;
            cmd_code    <= '0;
            abort_pulse <= 1'b0;
            drop_pulse  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            abort_pulse <= 1'b0;
            drop_pulse  <= 1'b0;
            case (state)
                IDLE: begin
                    if (whistle_pulse) begin
                        count <= CW'(1);
                        busy  <= 1'b1;
                        state <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (beep_pulse) begin
                        count       <= '0;
                        abort_pulse <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (!whistle_pulse && hold_done) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (beep_pulse) begin
                        count       <= '0;
                        abort_pulse <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (whistle_pulse) begin
                        if (count != CW'(MAX_COUNT)) begin
                            count <= count + CW'(1);
                        end
                        state <= HOLDOFF;
                    end else if (gap_done) begin
                        state <= PRESENT;
                    end
                end
                PRESENT: begin
                    // First cycle here loads the command register; later cycles wait for accept.
                    if (whistle_pulse) begin
                        drop_pulse <= 1'b1;
                    end
                    if (!cmd_valid) begin
                        cmd_valid <= 1'b1;
                        cmd_code  <= count;
                    end else if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        count     <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign live_count = count;

endmodule : whistle_sequence_decoder

// File: tb/tb_whistle_sequence_decoder.sv
// Directed bench for whistle_sequence_decoder with an elapsed-time reference model.
module tb_whistle_sequence_decoder;

    localparam int H    = 4;
    localparam int G    = 8;
    localparam int MAXC = 7;
    localparam int CW   = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          whistle_pulse = 1'b0;
    logic          beep_pulse = 1'b0;
    logic          cmd_ready = 1'b0;
    logic          cmd_valid;
    logic [CW-1:0] cmd_code;
    logic          abort_pulse;
    logic          drop_pulse;
    logic          busy;
    logic [CW-1:0] live_count;

    whistle_sequence_decoder #(
        .HOLDOFF_CYCLES (H),
        .GAP_CYCLES     (G),
        .MAX_COUNT      (MAXC),
        .CW             (CW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .whistle_pulse (whistle_pulse),
        .beep_pulse    (beep_pulse),
        .cmd_ready     (cmd_ready),
        .cmd_valid     (cmd_valid),
        .cmd_code      (cmd_code),
        .abort_pulse   (abort_pulse),
        .drop_pulse    (drop_pulse),
        .busy          (busy),
        .live_count    (live_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the sequence phase follows from edges elapsed since the last
    // counted/retriggering whistle rather than from any state encoding.
    int m_busy = 0, m_cnt = 0, m_valid = 0, m_code = 0, m_abort = 0, m_drop = 0;
    int last_w = 0;

    always @(posedge clk) begin
        int elapsed;
        cyc++;
        if (!reset_n) begin
            m_busy = 0; m_cnt = 0; m_valid = 0; m_code = 0; m_abort = 0; m_drop = 0;
        end else begin
            m_abort = 0;
            m_drop  = 0;
            if (m_busy == 0) begin
                if (whistle_pulse) begin
                    m_busy = 1; m_cnt = 1; last_w = cyc;
                end
            end else begin
                elapsed = cyc - last_w;
                if (elapsed <= H + G) begin
                    if (beep_pulse) begin
                        m_busy = 0; m_cnt = 0; m_abort = 1;
                    end else if (whistle_pulse) begin
                        if (elapsed > H && m_cnt < MAXC) m_cnt++;
                        last_w = cyc;
                    end
                end else begin
                    if (whistle_pulse) m_drop = 1;
                    if (m_valid == 0) begin
                        m_valid = 1; m_code = m_cnt;
                    end else if (cmd_ready) begin
                        m_valid = 0; m_busy = 0; m_cnt = 0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmd_valid",   32'(cmd_valid),   32'(m_valid));
            check("cmd_code",    32'(cmd_code),    32'(m_code));
            check("abort_pulse", 32'(abort_pulse), 32'(m_abort));
            check("drop_pulse",  32'(drop_pulse),  32'(m_drop));
            check("busy",        32'(busy),        32'(m_busy));
            check("live_count",  32'(live_count),  32'(m_cnt));
        end
    end

    // One clock: inputs set at the falling edge, sampled at the rising edge.
    task automatic tick(input logic w, input logic b, input logic r);
        whistle_pulse = w;
        beep_pulse    = b;
        cmd_ready     = r;
        @(posedge clk);
        @(negedge clk);
        whistle_pulse = 1'b0;
        beep_pulse    = 1'b0;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, r);
    endtask

    // n whistles, each followed by six quiet cycles except the last.
    task automatic spaced_whistles(input int n, input logic r);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, 1'b0, r);
            if (i < n - 1) idle(6, r);
        end
    endtask

    initial begin
        @(negedge clk);
        reset_n = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        check("reset cmd_valid", 32'(cmd_valid), 32'd0);
        check("reset busy",      32'(busy),      32'd0);
        check("reset live",      32'(live_count), 32'd0);
        reset_n = 1'b1;
        idle(3, 1'b1);

        // Beep while idle does nothing.
        tick(1'b0, 1'b1, 1'b1);
        check("idle beep busy", 32'(busy), 32'd0);

        // 1: single whistle, consumer always ready.
        tick(1'b1, 1'b0, 1'b1);
        check("s1 busy",  32'(busy),       32'd1);
        check("s1 live",  32'(live_count), 32'd1);
        idle(12, 1'b1);
        check("s1 valid early", 32'(cmd_valid), 32'd0);
        tick(1'b0, 1'b0, 1'b1);
        check("s1 valid",  32'(cmd_valid), 32'd1);
        check("s1 code",   32'(cmd_code),  32'd1);
        tick(1'b0, 1'b0, 1'b1);
        check("s1 valid drop", 32'(cmd_valid), 32'd0);
        check("s1 busy end",   32'(busy),      32'd0);
        idle(3, 1'b1);

        // 2: retriggered hold-off makes one event.
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (i < 3) tick(1'b0, 1'b0, 1'b1);
        end
        check("s2 live", 32'(live_count), 32'd1);
        idle(12, 1'b1);
        check("s2 valid early", 32'(cmd_valid), 32'd0);
        tick(1'b0, 1'b0, 1'b1);
        check("s2 valid", 32'(cmd_valid), 32'd1);
        check("s2 code",  32'(cmd_code),  32'd1);
        idle(3, 1'b1);

        // 3: three separated whistles.
        tick(1'b1, 1'b0, 1'b1);
        check("s3 live1", 32'(live_count), 32'd1);
        idle(6, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        check("s3 live2", 32'(live_count), 32'd2);
        idle(6, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        check("s3 live3", 32'(live_count), 32'd3);
        idle(13, 1'b1);
        check("s3 code", 32'(cmd_code), 32'd3);
        idle(3, 1'b1);

        // 4: ten whistles saturate at MAX_COUNT.
        spaced_whistles(10, 1'b1);
        check("s4 live sat", 32'(live_count), 32'd7);
        idle(13, 1'b1);
        check("s4 valid", 32'(cmd_valid), 32'd1);
        check("s4 code",  32'(cmd_code),  32'd7);
        idle(3, 1'b1);

        // 5: beep during the gap aborts.
        spaced_whistles(2, 1'b1);
        idle(6, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        check("s5 abort", 32'(abort_pulse), 32'd1);
        check("s5 busy",  32'(busy),        32'd0);
        tick(1'b0, 1'b0, 1'b1);
        check("s5 abort once", 32'(abort_pulse), 32'd0);
        idle(20, 1'b1);
        check("s5 no valid", 32'(cmd_valid), 32'd0);

        // 6a: whistle and beep together in hold-off.
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        check("s6 abort", 32'(abort_pulse), 32'd1);
        check("s6 busy",  32'(busy),        32'd0);
        idle(3, 1'b0);

        // 6b: command held with consumer stalled; stray whistle is dropped.
        tick(1'b1, 1'b0, 1'b0);
        idle(13, 1'b0);
        check("s6 valid", 32'(cmd_valid), 32'd1);
        idle(5, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("s6 drop",      32'(drop_pulse), 32'd1);
        check("s6 code held", 32'(cmd_code),   32'd1);
        tick(1'b0, 1'b1, 1'b0);
        check("s6 drop once", 32'(drop_pulse), 32'd0);
        check("s6 beep ignored", 32'(cmd_valid), 32'd1);
        idle(10, 1'b0);

        // 6c: reset while presenting clears everything.
        reset_n = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        check("rst valid", 32'(cmd_valid),   32'd0);
        check("rst code",  32'(cmd_code),    32'd0);
        check("rst busy",  32'(busy),        32'd0);
        check("rst live",  32'(live_count),  32'd0);
        check("rst abort", 32'(abort_pulse), 32'd0);
        check("rst drop",  32'(drop_pulse),  32'd0);
        tick(1'b1, 1'b0, 1'b1);
        check("post rst busy", 32'(busy), 32'd1);
        idle(16, 1'b1);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_whistle_sequence_decoder
